dcache_data_arbiter: RTL and testbench

- Sequences and shares the single-port, byte-masked data cache SRAM: 16 lines × 256 bits, 32 byte write-enables, inputs registered at the clock edge.
- Two requesters share it:
  - Port A: core load/store path.
  - Port B: line fill/evict engine.
- After reset, it zero-clears every line before granting any access.
- It arbitrates between A and B, drives the SRAM control pins and returns read data with a valid strobe.

---
 rtl/dcache_data_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dcache_data_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_data_arbiter.sv
// Data-cache SRAM sequencer: zero-clears the array after reset, then arbitrates core (A) vs fill/evict (B).
// Define DCACHE_ARB_PERF_EN to add saturating contention/starvation/lock-stall counters.
module dcache_data_arbiter #(
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_WMASKS   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic                  b_lock,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  init_done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [15:0]           perf_conflicts,
  output logic [15:0]           perf_starve,
  output logic [15:0]           perf_lock_stall
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  lock_q, lock_d;
  logic                  starve_hit;
  logic                  vld_p1;
  logic                  tag_b_p1;

  function automatic logic [SW-1:0] sat_starve(input logic [SW-1:0] v);
    return (v >= SW'(STARVE_LIMIT)) ? SW'(STARVE_LIMIT) : v + SW'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    starve_hit = (starve_q == SW'(STARVE_LIMIT));
    case (state_q)
      S_INIT: begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_wmask = '1;
        sram_addr  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_ARB;
      end
      S_ARB: begin
        // A held lock parks A entirely, even when it is due a forced win.
        if (lock_q) begin
          b_gnt = b_req;
        end else if (a_req && b_req) begin
          a_gnt = starve_hit;
          b_gnt = !starve_hit;
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
        if (a_gnt) begin
          sram_csb   = 1'b0;
          sram_web   = !a_we;
          sram_addr  = a_addr;
          sram_wmask = a_we ? a_wmask : '0;
          sram_din   = a_wdata;
        end else if (b_gnt) begin
          sram_csb   = 1'b0;
          sram_web   = !b_we;
          sram_addr  = b_addr;
          sram_wmask = b_we ? b_wmask : '0;
          sram_din   = b_wdata;
        end
      end
      default: state_d = S_INIT;
    endcase
    // Reset is asynchronous, so the SRAM must be deselected the instant it asserts.
    if (rst) begin
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      sram_csb = 1'b1;
      sram_web = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (a_gnt)      starve_d = '0;
    else if (a_req) starve_d = sat_starve(starve_q);
    lock_d = lock_q;
    if (!b_lock)    lock_d = 1'b0;
    else if (b_gnt) lock_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      starve_q   <= '0;
      lock_q     <= 1'b0;
      vld_p1     <= 1'b0;
      tag_b_p1   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      starve_q   <= starve_d;
      lock_q     <= lock_d;
      // p0 -> p1: SRAM registers the read address; data appears on sram_dout one cycle later.
      vld_p1     <= (a_gnt && !a_we) || (b_gnt && !b_we);
      tag_b_p1   <= b_gnt;
    end
  end

  assign a_rvalid  = vld_p1 && !tag_b_p1;
  assign b_rvalid  = vld_p1 && tag_b_p1;
  assign a_rdata   = sram_dout;
  assign b_rdata   = sram_dout;
  assign init_done = (state_q == S_ARB);

`ifdef DCACHE_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conflicts  <= '0;
      perf_starve     <= '0;
      perf_lock_stall <= '0;
    end else begin
      perf_conflicts  <= sat_inc16(perf_conflicts, a_req && b_req);
      perf_starve     <= sat_inc16(perf_starve, a_gnt && b_req);
      perf_lock_stall <= sat_inc16(perf_lock_stall, a_req && lock_q);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_data_arbiter.sv
// Self-checking bench for dcache_data_arbiter: behavioural SRAM, reference memory and read scoreboard.
module tb_dcache_data_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_req, a_we, a_gnt, a_rvalid;
  logic [3:0]   a_addr;
  logic [31:0]  a_wmask;
  logic [255:0] a_wdata, a_rdata;
  logic         b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [3:0]   b_addr;
  logic [31:0]  b_wmask;
  logic [255:0] b_wdata, b_rdata;
  logic         init_done, sram_csb, sram_web;
  logic [31:0]  sram_wmask;
  logic [3:0]   sram_addr;
  logic [255:0] sram_din, sram_dout;
`ifdef DCACHE_ARB_PERF_EN
  logic [15:0]  perf_conflicts, perf_starve, perf_lock_stall;
`endif

  dcache_data_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wmask(a_wmask), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done), .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef DCACHE_ARB_PERF_EN
    , .perf_conflicts(perf_conflicts), .perf_starve(perf_starve), .perf_lock_stall(perf_lock_stall)
`endif
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered inputs and byte write enables.
  logic [255:0] mem [16];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int i = 0; i < 32; i++)
          if (sram_wmask[i]) mem[sram_addr][i*8 +: 8] <= sram_din[i*8 +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic         is_b;
    logic [255:0] data;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  logic [255:0] ref_mem [16];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] din,
                                         input logic [31:0] m);
    logic [255:0] r;
    r = old;
    for (int i = 0; i < 32; i++) if (m[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wmask = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wmask = '0; b_wdata = '0; b_lock = 1'b0;
  endtask

  // One ARB cycle: inputs already driven; ea/eb are the grants the bench expects.
  task automatic run_cycle(input logic ea, input logic eb);
    exp_t         e;
    logic         we;
    logic [3:0]   ad;
    logic [31:0]  wm;
    logic [255:0] wd;
    #3;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check_eq("a_rvalid", 256'(a_rvalid), 256'(!e.is_b));
      check_eq("b_rvalid", 256'(b_rvalid), 256'(e.is_b));
      check_eq("rdata", e.is_b ? b_rdata : a_rdata, e.data);
    end else begin
      check_eq("a_rvalid_idle", 256'(a_rvalid), 256'(0));
      check_eq("b_rvalid_idle", 256'(b_rvalid), 256'(0));
    end
    check_eq("a_gnt", 256'(a_gnt), 256'(ea));
    check_eq("b_gnt", 256'(b_gnt), 256'(eb));
    check_eq("sram_csb", 256'(sram_csb), 256'(!(ea || eb)));
    if (ea || eb) begin
      we = ea ? a_we : b_we;
      ad = ea ? a_addr : b_addr;
      wm = ea ? a_wmask : b_wmask;
      wd = ea ? a_wdata : b_wdata;
      check_eq("sram_web", 256'(sram_web), 256'(!we));
      check_eq("sram_addr", 256'(sram_addr), 256'(ad));
      if (we) begin
        check_eq("sram_wmask", 256'(sram_wmask), 256'(wm));
        check_eq("sram_din", sram_din, wd);
        ref_mem[ad] = merge(ref_mem[ad], wd, wm);
      end else begin
        check_eq("sram_wmask_rd", 256'(sram_wmask), 256'(0));
        e.is_b = eb; e.data = ref_mem[ad]; e.due = cyc + 1;
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Checks n cycles of the clear sequence starting at address 0.
  task automatic init_check(input int n);
    for (int i = 0; i < n; i++) begin
      #3;
      check_eq("init_csb", 256'(sram_csb), 256'(0));
      check_eq("init_web", 256'(sram_web), 256'(0));
      check_eq("init_addr", 256'(sram_addr), 256'(i));
      check_eq("init_wmask", 256'(sram_wmask), 256'(32'hFFFF_FFFF));
      check_eq("init_din", sram_din, 256'(0));
      check_eq("init_done_lo", 256'(init_done), 256'(0));
      check_eq("init_gnt", 256'({a_gnt, b_gnt}), 256'(0));
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic reset_checks();
    check_eq("rst_init_done", 256'(init_done), 256'(0));
    check_eq("rst_a_gnt", 256'(a_gnt), 256'(0));
    check_eq("rst_b_gnt", 256'(b_gnt), 256'(0));
    check_eq("rst_rvalid", 256'({a_rvalid, b_rvalid}), 256'(0));
    check_eq("rst_csb", 256'(sram_csb), 256'(1));
    check_eq("rst_web", 256'(sram_web), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #3;
    reset_checks();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    init_check(16);
    #3;
    check_eq("init_done_hi", 256'(init_done), 256'(1));
    @(posedge clk); #1;
    cyc++;

    // Cleared lines read back as zero.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;  run_cycle(1'b1, 1'b0);
    a_addr = 4'd15;                            run_cycle(1'b1, 1'b0);
    idle_inputs(); b_req = 1'b1; b_addr = 4'd9; run_cycle(1'b0, 1'b1);

    // Partial write then immediate read of the same line.
    idle_inputs();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wmask = 32'h0000_000F; a_wdata = {32{8'hA5}};
    run_cycle(1'b1, 1'b0);
    a_we = 1'b0; a_wmask = '0; a_wdata = '0;
    run_cycle(1'b1, 1'b0);
    idle_inputs();
    run_cycle(1'b0, 1'b0);
    check_eq("raw_low_word", 256'(ref_mem[3][31:0]), 256'(32'hA5A5_A5A5));

    // Continuous contention: B wins four, then A is forced in.
    for (int k = 0; k < 10; k++) begin
      a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
      b_req = 1'b1; b_we = 1'b1; b_addr = 4'd10; b_wmask = '1;
      b_wdata = {8{32'hC0DE_0000 + 32'(k)}};
      run_cycle((k % 5) == 4, (k % 5) != 4);
    end
`ifdef DCACHE_ARB_PERF_EN
    check_eq("perf_conflicts", 256'(perf_conflicts), 256'(10));
    check_eq("perf_starve", 256'(perf_starve), 256'(2));
`endif
    idle_inputs();
    run_cycle(1'b0, 1'b0);

    // Locked evict-then-fill sequence on line 7 while A waits.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7; b_lock = 1'b1;
    run_cycle(1'b0, 1'b1);
    b_req = 1'b0;
    run_cycle(1'b0, 1'b0);
    b_req = 1'b1; b_we = 1'b1; b_wmask = 32'hFF00_FF00; b_wdata = {8{32'h1234_5678}};
    run_cycle(1'b0, 1'b1);
    b_req = 1'b0; b_we = 1'b0; b_wmask = '0; b_lock = 1'b0;
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    idle_inputs();
    b_req = 1'b1; b_addr = 4'd7;
    run_cycle(1'b0, 1'b1);
    idle_inputs();
    run_cycle(1'b0, 1'b0);

    // Reset in the middle of the clear sequence.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    sbq.delete();
    init_check(9);
    #3;
    rst = 1'b1;
    a_req = 1'b1;
    #1;
    reset_checks();
    @(posedge clk); #1;
    a_req = 1'b0;
    rst = 1'b0;
    init_check(16);
    #3;
    check_eq("reinit_done", 256'(init_done), 256'(1));
    @(posedge clk); #1;
    cyc++;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7;
    run_cycle(1'b1, 1'b0);
    idle_inputs();
    b_req = 1'b1; b_addr = 4'd3;
    run_cycle(1'b0, 1'b1);
    idle_inputs();
    run_cycle(1'b0, 1'b0);
    check_eq("scoreboard_drained", 256'(sbq.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
